// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
// Owner encoding tells the fill sequencer which cache receives the burst.
package mem_arb_pkg;

  localparam int          WORDS_PER_BLOCK = 8;
  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;
  localparam logic [2:0]  LAST_WORD       = 3'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return addr & BLOCK_MASK;
  endfunction

endpackage

// File: rtl/cnt_3bit.sv
// 3-bit up-counter with synchronous clear and enable; clear wins over enable.
// Used for the fill issue index and the fill receive index.
module cnt_3bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] cnt
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (en) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache fills, D-cache fills and D-cache
// write-through stores; sequences 8-word fill bursts and pulses completion.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        dcache_wr_req,
  input  logic [15:0] dcache_wr_addr,
  input  logic [15:0] dcache_wr_data,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        icache_fill_we,
  output logic        dcache_fill_we,
  output logic        icache_tag_we,
  output logic        dcache_tag_we,
  output logic        ifill_done,
  output logic        dfill_done,
  output logic        wr_done,
  output logic        busy
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [15:0] base_q, base_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        issuing_q, issuing_d;

  logic [2:0]  issue_cnt;
  logic [2:0]  rx_cnt;
  logic        cnt_clr;
  logic        issue_en;
  logic        rx_en;
  logic        rx_last;

  // Both indices restart whenever the arbiter is idle, so every fill begins at word 0.
  assign cnt_clr  = (state_q == IDLE);
  assign issue_en = (state_q == FILL) && issuing_q;
  assign rx_en    = (state_q == FILL) && mem_data_valid;
  assign rx_last  = rx_en && (rx_cnt == LAST_WORD);

  cnt_3bit u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt)
  );

  cnt_3bit u_rx_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (rx_en),
    .cnt (rx_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_I;
      base_q    <= 16'd0;
      wr_addr_q <= 16'd0;
      wr_data_q <= 16'd0;
      issuing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      issuing_q <= issuing_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    issuing_d = issuing_q;
    case (state_q)
      IDLE: begin
        issuing_d = 1'b0;
        // D-side requests belong to the older instruction, so they win.
        if (dcache_miss) begin
          state_d   = FILL;
          owner_d   = OWNER_D;
          base_d    = block_base(dcache_miss_addr);
          issuing_d = 1'b1;
        end else if (dcache_wr_req) begin
          state_d   = WRITE;
          wr_addr_d = dcache_wr_addr;
          wr_data_d = dcache_wr_data;
        end else if (icache_miss) begin
          state_d   = FILL;
          owner_d   = OWNER_I;
          base_d    = block_base(icache_miss_addr);
          issuing_d = 1'b1;
        end
      end
      FILL: begin
        // The 3-bit issue index wraps, so a flag marks the end of the issue phase.
        if (issue_en && (issue_cnt == LAST_WORD)) begin
          issuing_d = 1'b0;
        end
        if (rx_last) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = 16'd0;
    mem_data_out   = 16'd0;
    fill_data      = 16'd0;
    fill_word      = 3'd0;
    icache_fill_we = 1'b0;
    dcache_fill_we = 1'b0;
    icache_tag_we  = 1'b0;
    dcache_tag_we  = 1'b0;
    ifill_done     = 1'b0;
    dfill_done     = 1'b0;
    wr_done        = 1'b0;
    busy           = (state_q != IDLE);
    case (state_q)
      FILL: begin
        if (issuing_q) begin
          mem_enable = 1'b1;
          mem_addr   = base_q + {12'd0, issue_cnt, 1'b0};
        end
        if (mem_data_valid) begin
          fill_data = mem_data_in;
          fill_word = rx_cnt;
          if (owner_q == OWNER_D) begin
            dcache_fill_we = 1'b1;
            dcache_tag_we  = (rx_cnt == LAST_WORD);
            dfill_done     = (rx_cnt == LAST_WORD);
          end else begin
            icache_fill_we = 1'b1;
            icache_tag_we  = (rx_cnt == LAST_WORD);
            ifill_done     = (rx_cnt == LAST_WORD);
          end
        end
      end
      WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = wr_addr_q;
        mem_data_out = wr_data_q;
        wr_done      = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model pushes expected
// reads, fill writes, stores and completion order; a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int MEM_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss, dcache_wr_req;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_out, fill_data;
  logic [2:0]  fill_word;
  logic        icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we;
  logic        ifill_done, dfill_done, wr_done, busy;

  mem_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .dcache_wr_req    (dcache_wr_req),
    .dcache_wr_addr   (dcache_wr_addr),
    .dcache_wr_data   (dcache_wr_data),
    .mem_data_in      (mem_data_in),
    .mem_data_valid   (mem_data_valid),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_data_out     (mem_data_out),
    .fill_data        (fill_data),
    .fill_word        (fill_word),
    .icache_fill_we   (icache_fill_we),
    .dcache_fill_we   (dcache_fill_we),
    .icache_tag_we    (icache_tag_we),
    .dcache_tag_we    (dcache_tag_we),
    .ifill_done       (ifill_done),
    .dfill_done       (dfill_done),
    .wr_done          (wr_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_s = 1'b1;
  logic [15:0] salt;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rsp_t;

  typedef struct packed {
    logic        is_d;
    logic [2:0]  word;
    logic [15:0] data;
    logic        last;
  } fexp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wexp_t;

  rsp_t        rsp_q[$];
  logic [15:0] exp_rd[$];
  fexp_t       exp_fill[$];
  wexp_t       exp_wr[$];
  logic [2:0]  exp_done[$];

  int lat = MEM_LATENCY;
  int gap = 0;
  int last_valid_cyc = -100;
  bit toggle_mode = 1'b0;
  bit prev_done = 1'b0;
  int idone_cnt = 0, ddone_cnt = 0, wdone_cnt = 0;
  int idone_cyc = 0, ddone_cyc = 0, wdone_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] p;
    p = {16'd0, a} * 32'h0000_9E37;
    return p[15:0] ^ 16'h5A3C ^ salt;
  endfunction

  // Reference model: a fill is 8 reads of the aligned block, then 8 in-order writes.
  task automatic expect_fill(input bit is_d, input logic [15:0] addr);
    logic [15:0] base;
    logic [15:0] a;
    fexp_t e;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      exp_rd.push_back(a);
      e.is_d = is_d;
      e.word = 3'(k);
      e.data = mem_word(a);
      e.last = (k == 7);
      exp_fill.push_back(e);
    end
    exp_done.push_back(is_d ? 3'b010 : 3'b001);
  endtask

  task automatic expect_write(input logic [15:0] addr, input logic [15:0] data);
    wexp_t w;
    w.addr = addr;
    w.data = data;
    exp_wr.push_back(w);
    exp_done.push_back(3'b100);
  endtask

  task automatic flush_model();
    exp_rd.delete();
    exp_fill.delete();
    exp_wr.delete();
    exp_done.delete();
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_s = rst;
  end

  // Memory model: in-order responses after lat cycles, at least gap idle cycles apart.
  always @(posedge clk) begin
    #1;
    if (toggle_mode) begin
      mem_data_valid = cyc[0];
      mem_data_in    = 16'($urandom);
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc && cyc >= last_valid_cyc + gap + 1) begin
      mem_data_valid = 1'b1;
      mem_data_in    = rsp_q[0].data;
      void'(rsp_q.pop_front());
      last_valid_cyc = cyc;
    end else begin
      mem_data_valid = 1'b0;
      mem_data_in    = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    logic [2:0] dn;
    fexp_t e;
    wexp_t w;
    logic [15:0] ra;
    if (rst_s) begin
      chk("reset_outputs",
          {mem_enable, mem_wr, mem_addr, mem_data_out, fill_data, fill_word,
           icache_fill_we, dcache_fill_we, icache_tag_we, dcache_tag_we,
           ifill_done, dfill_done, wr_done, busy}, 64'd0);
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", busy, 1'b0);
      if (mem_enable && !mem_wr) begin
        if (exp_rd.size() == 0) unexpected("unexpected_read", mem_addr);
        else begin
          ra = exp_rd.pop_front();
          chk("rd_addr", mem_addr, ra);
        end
        rsp_q.push_back('{mem_word(mem_addr), cyc + lat});
      end
      if (!mem_enable) chk("idle_addr_zero", mem_addr, 16'd0);
      if (mem_enable && mem_wr) begin
        if (exp_wr.size() == 0) unexpected("unexpected_write", mem_addr);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_data_out, w.data);
          chk("wr_done_with_write", wr_done, 1'b1);
        end
      end else if (wr_done) begin
        unexpected("wr_done_without_write", wr_done);
      end
      if (icache_fill_we || dcache_fill_we) begin
        if (exp_fill.size() == 0) unexpected("unexpected_fill", {fill_word, fill_data});
        else begin
          e = exp_fill.pop_front();
          chk("fill_owner", {icache_fill_we, dcache_fill_we}, e.is_d ? 2'b01 : 2'b10);
          chk("fill_word", fill_word, e.word);
          chk("fill_data", fill_data, e.data);
          chk("fill_tag_done", {icache_tag_we, dcache_tag_we, ifill_done, dfill_done},
              e.last ? (e.is_d ? 4'b0101 : 4'b1010) : 4'b0000);
        end
      end else begin
        chk("no_fill_tag_done", {icache_tag_we, dcache_tag_we, ifill_done, dfill_done}, 4'b0000);
      end
      dn = {wr_done, dfill_done, ifill_done};
      if (dn != 3'b000) begin
        if (exp_done.size() == 0) unexpected("unexpected_done", dn);
        else chk("done_order", dn, exp_done.pop_front());
      end
      if (ifill_done) begin idone_cnt++; idone_cyc = cyc; end
      if (dfill_done) begin ddone_cnt++; ddone_cyc = cyc; end
      if (wr_done)    begin wdone_cnt++; wdone_cyc = cyc; end
      prev_done = (dn != 3'b000);
    end
  end

  // Raises the requested lines together; each requester drops on its own done.
  task automatic run_batch(input bit dm, input bit wr, input bit im,
                           input logic [15:0] da, input logic [15:0] wa,
                           input logic [15:0] wd, input logic [15:0] ia,
                           input int lat_i, input int gap_i, input bit check_lat);
    int i0, d0, w0, t0;
    @(posedge clk); #1;
    lat = lat_i;
    gap = gap_i;
    if (dm) expect_fill(1'b1, da);
    if (wr) expect_write(wa, wd);
    if (im) expect_fill(1'b0, ia);
    dcache_miss = dm;  dcache_miss_addr = da;
    dcache_wr_req = wr; dcache_wr_addr = wa; dcache_wr_data = wd;
    icache_miss = im;  icache_miss_addr = ia;
    t0 = cyc;
    i0 = idone_cnt; d0 = ddone_cnt; w0 = wdone_cnt;
    for (int n = 0; n < 400 && (dcache_miss || dcache_wr_req || icache_miss); n++) begin
      @(posedge clk); #1;
      if (idone_cnt != i0 && icache_miss) begin
        icache_miss = 1'b0;
        if (check_lat) chk("ifill_latency", idone_cyc - t0, 12);
      end
      if (ddone_cnt != d0 && dcache_miss) begin
        dcache_miss = 1'b0;
        if (check_lat) chk("dfill_latency", ddone_cyc - t0, 12);
      end
      if (wdone_cnt != w0 && dcache_wr_req) begin
        dcache_wr_req = 1'b0;
        if (check_lat) chk("wr_latency", wdone_cyc - t0, 1);
      end
    end
    if (dcache_miss || dcache_wr_req || icache_miss) begin
      unexpected("batch_timeout", {dcache_miss, dcache_wr_req, icache_miss});
      dcache_miss = 1'b0; dcache_wr_req = 1'b0; icache_miss = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      flush_model();
      rsp_q.delete();
    end
    $display("batch dm=%0d wr=%0d im=%0d da=%h wa=%h ia=%h lat=%0d gap=%0d errors=%0d",
             dm, wr, im, da, wa, ia, lat_i, gap_i, errors);
    chk("model_drained", exp_rd.size() + exp_fill.size() + exp_wr.size() + exp_done.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d_snap;
    salt = 16'($urandom);
    rst = 1'b1;
    icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr_req = 1'b0;
    icache_miss_addr = 16'd0; dcache_miss_addr = 16'd0;
    dcache_wr_addr = 16'd0; dcache_wr_data = 16'd0;
    mem_data_in = 16'd0; mem_data_valid = 1'b0;
    toggle_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 toggle_mode = 1'b0;

    // I-cache fill with nominal latency
    run_batch(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0126, 4, 0, 1'b1);
    // all three requesters at once
    run_batch(1'b1, 1'b1, 1'b1, 16'h4008, 16'h400A, 16'h1234, 16'h2346, 4, 0, 1'b0);
    // single store
    run_batch(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0A02, 16'hBEEF, 16'h0000, 4, 0, 1'b1);
    // block at the top of the address space
    run_batch(1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 4, 0, 1'b1);

    // reset in cycle 6 of a D fill
    @(posedge clk); #1;
    lat = 4; gap = 0;
    expect_fill(1'b1, 16'h7F3A);
    dcache_miss = 1'b1; dcache_miss_addr = 16'h7F3A;
    d_snap = ddone_cnt;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; dcache_miss = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    flush_model();
    for (int n = 0; n < 30 && rsp_q.size() > 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("late_valids_consumed", rsp_q.size(), 0);
    chk("abort_no_dfill_done", ddone_cnt, d_snap);
    $display("abort test done errors=%0d", errors);
    run_batch(1'b1, 1'b0, 1'b0, 16'h7F3A, 16'h0000, 16'h0000, 16'h0000, 4, 0, 1'b1);

    // stalled memory: three idle cycles between words
    run_batch(1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, 16'h0000, 16'h0000, 4, 3, 1'b0);
    run_batch(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0C00, 16'h55AA, 16'h9876, 2, 3, 1'b0);

    for (int it = 0; it < 40; it++) begin
      bit dm, wr, im;
      dm = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      im = 1'($urandom_range(0, 1));
      if (!(dm || wr || im)) im = 1'b1;
      run_batch(dm, wr, im, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 6), $urandom_range(0, 2), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
